// File: rtl/interrupt_controller_pkg.sv
// Shared pipeline definitions for the interrupt controller: FSM state
// encoding and memory-stage data-select codes used during context push.
package interrupt_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_PUSH_HI  = 3'd2,
    ST_PUSH_LO  = 3'd3,
    ST_PUSH_FLG = 3'd4,
    ST_VECTOR   = 3'd5
  } ic_state_e;

  localparam logic [1:0] MSEL_NORMAL = 2'b00;
  localparam logic [1:0] MSEL_PC_HI  = 2'b01;
  localparam logic [1:0] MSEL_PC_LO  = 2'b10;
  localparam logic [1:0] MSEL_FLAGS  = 2'b11;

endpackage

// File: rtl/interrupt_controller.sv
// Interrupt entry sequencer: flush, push PC/flags, vector, track service.
// Optional INT_PENDING_EN keeps a one-bit latch for requests seen while busy.
module interrupt_controller
  import interrupt_controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        int_req,
  input  logic        rti_i,
  input  logic [31:0] pc_i,
  input  logic [3:0]  flags_i,
  output logic [31:0] save_pc_o,
  output logic [3:0]  save_flags_o,
  output logic [1:0]  mem_sel_o,
  output logic        pc_stall_o,
  output logic        if_flush_o,
  output logic        id_flush_o,
  output logic        vector_sel_o,
  output logic        in_service_o,
  output logic        busy_o
);

  ic_state_e state;
  ic_state_e state_nxt;
  logic      in_service;
  logic      req_seen;
  logic      accept;

`ifdef INT_PENDING_EN
  logic pending;
  assign req_seen = int_req | pending;
`else
  assign req_seen = int_req;
`endif

  // in_service is the registered value, so an RTI retiring this cycle
  // delays any new entry by one edge.
  assign accept = (state == ST_IDLE) && req_seen && !in_service;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (accept) state_nxt = ST_FLUSH;
      ST_FLUSH:    state_nxt = ST_PUSH_HI;
      ST_PUSH_HI:  state_nxt = ST_PUSH_LO;
      ST_PUSH_LO:  state_nxt = ST_PUSH_FLG;
      ST_PUSH_FLG: state_nxt = ST_VECTOR;
      ST_VECTOR:   state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      in_service   <= 1'b0;
      save_pc_o    <= '0;
      save_flags_o <= '0;
`ifdef INT_PENDING_EN
      pending      <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        save_pc_o    <= pc_i;
        save_flags_o <= flags_i;
      end
      if (state == ST_VECTOR)
        in_service <= 1'b1;
      else if (rti_i)
        in_service <= 1'b0;
`ifdef INT_PENDING_EN
      if (accept)
        pending <= 1'b0;
      else if (int_req && ((state != ST_IDLE) || in_service))
        pending <= 1'b1;
`endif
    end
  end

  always_comb begin
    mem_sel_o    = MSEL_NORMAL;
    pc_stall_o   = 1'b0;
    if_flush_o   = 1'b0;
    id_flush_o   = 1'b0;
    vector_sel_o = 1'b0;
    case (state)
      ST_FLUSH: begin
        pc_stall_o = 1'b1;
        if_flush_o = 1'b1;
        id_flush_o = 1'b1;
      end
      ST_PUSH_HI: begin
        pc_stall_o = 1'b1;
        mem_sel_o  = MSEL_PC_HI;
      end
      ST_PUSH_LO: begin
        pc_stall_o = 1'b1;
        mem_sel_o  = MSEL_PC_LO;
      end
      ST_PUSH_FLG: begin
        pc_stall_o = 1'b1;
        mem_sel_o  = MSEL_FLAGS;
      end
      ST_VECTOR:   vector_sel_o = 1'b1;
      default:     ;
    endcase
  end

  assign in_service_o = in_service;
  assign busy_o       = (state != ST_IDLE);

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Clocking and reset SHALL be one clock, with a synchronous, active-high reset: clk, reset.
REQ-002 clk  in  1  pipeline clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 int_req  in  1  external interrupt pin, level, sampled each posedge.
REQ-005 rti_i  in  1  one-cycle pulse when an RTI retires; ends service.
REQ-006 pc_i  in  32  resume PC from IF/ID buffer, captured on entry.
REQ-007 flags_i  in  4  ALU flags (Z,N,C,V), captured on entry.
REQ-008 save_pc_o  out  32  captured resume PC, held until next capture.
REQ-009 save_flags_o  out  4  captured flags.
REQ-010 mem_sel_o  out  2  memory-stage data select: 00 normal, 01 push PC[31:16], 10 push PC[15:0], 11 push flags.
REQ-011 pc_stall_o  out  1  freeze PC and IF/ID write.
REQ-012 if_flush_o, id_flush_o  out  1 each  flush IF/ID and ID/IE buffers.
REQ-013 vector_sel_o  out  1  fetch mux selects interrupt vector PC.
REQ-014 in_service_o  out  1  handler executing.
REQ-015 busy_o  out  1  FSM not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, FLUSH, PUSH_HI, PUSH_LO, PUSH_FLG and VECTOR, and each non-IDLE state SHALL last exactly one cycle.
REQ-017 The FSM SHALL take IDLE->FLUSH at posedge when a request is accepted: (int_req or pending) and not in_service.
REQ-018 On the IDLE->FLUSH edge, the block SHALL capture save_pc_o<=pc_i and save_flags_o<=flags_i.
REQ-019 FLUSH SHALL assert if_flush_o=1, id_flush_o=1 and pc_stall_o=1 with mem_sel_o=00.
REQ-020 PUSH_HI, PUSH_LO and PUSH_FLG SHALL assert pc_stall_o=1 with mem_sel_o=01, 10 and 11 respectively, and flushes=0.
REQ-021 VECTOR SHALL assert vector_sel_o=1 and pc_stall_o=0, and SHALL set in_service at the VECTOR->IDLE edge.
REQ-022 All outputs SHALL be decoded from registered state only; none SHALL depend combinationally on int_req.
REQ-023 Latency SHALL be as follows: request sampled at edge N; FLUSH outputs during cycle N..N+1; vector_sel_o high during the 5th busy cycle; busy_o high for exactly 5 cycles.
REQ-024 rti_i SHALL clear in_service at the next posedge; rti_i while not in_service SHALL be ignored.
REQ-025 When int_req and rti_i arrive in the same cycle, in_service SHALL clear first and the request SHALL be accepted one cycle later (no same-edge entry).
REQ-026 Requests arriving while busy or in_service SHALL be handled per REQ-030/031, and the block SHALL never nest.

Reset
REQ-027 On reset, state SHALL be IDLE, in_service=0, pending=0, save_pc_o=0, save_flags_o=0 and all control outputs=0.
REQ-028 Reset asserted mid-sequence SHALL abort to IDLE at that edge, with no further push selects issued.
REQ-029 Reset SHALL override rti_i and int_req on the same edge.

Configuration
REQ-030 With INT_PENDING_EN defined, a one-bit pending latch SHALL set on any sampled int_req while busy or in_service, clear on acceptance, and be serviced at the first IDLE cycle after in_service clears.
REQ-031 Without INT_PENDING_EN, no pending latch SHALL exist, and requests while busy or in_service SHALL be dropped unless int_req is still high when acceptance becomes possible.

Structure
REQ-032 The shared pipeline package SHALL hold the state enum and the mem_sel encodings (MSEL_NORMAL, MSEL_PC_HI, MSEL_PC_LO, MSEL_FLAGS).
REQ-033 The block SHALL be a single module with no sub-modules; the FSM and capture registers SHALL be in one always block on clk, with a separate combinational output decode.

Verification
REQ-034 A bench SHALL check: int_req pulse 1 cycle, pc_i=32'h0000_0120, flags_i=4'b1010 -> save_pc_o=0x120, save_flags_o=0xA; mem_sel_o sequence 00,01,10,11,00 over 5 cycles; vector_sel_o only in cycle 5.
REQ-035 A bench SHALL check: int_req high during in_service, then rti_i pulse, with INT_PENDING_EN -> new FLUSH begins 1 cycle after in_service falls.
REQ-036 A bench SHALL check: same stimulus without INT_PENDING_EN and int_req low at rti -> no second entry; busy_o stays 0.
REQ-037 A bench SHALL check: reset asserted during PUSH_LO -> next cycle all outputs 0, state IDLE, save_pc_o=0.
REQ-038 A bench SHALL check: int_req and rti_i in the same cycle while in_service -> in_service 0 at next edge, FLUSH one edge later.
REQ-039 A bench SHALL check: rti_i while idle -> no output change.
